// File: rtl/serial_adder_nbit_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_nbit_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, carry_out
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, carry_out
   );
endinterface

// File: rtl/serial_adder_nbit.sv
// Bit-serial LSB-first adder: {carry_out,sum} = a + b + cin, one bit per clock.
// A carry flip-flop links the bits; each bit is a full adder made of two half adders.
module serial_adder_nbit #(
   parameter int unsigned WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   serial_adder_nbit_if.slave bus
);
   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Full adder on the current LSBs, built from two half-adder cells.
   logic ha1_s, ha1_c, ha2_c, bit_s, bit_c;
   assign ha1_s = a_q[0] ^ b_q[0];
   assign ha1_c = a_q[0] & b_q[0];
   assign bit_s = ha1_s ^ carry_q;
   assign ha2_c = ha1_s & carry_q;
   assign bit_c = ha1_c | ha2_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ADD;
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
            end
         end
         ADD: begin
            // New bit enters at the MSB so bit i settles at sum[i] after WIDTH shifts.
            sum_d   = {bit_s, sum_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = bit_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               cout_d  = bit_c;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder_nbit.sv
// Scoreboard bench for serial_adder_nbit: stimulus pushes a+b+cin, a monitor checks each done pulse.
module tb_serial_adder_nbit;
   localparam int unsigned WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_adder_nbit_if #(.WIDTH(WIDTH)) bus ();

   serial_adder_nbit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [WIDTH:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin);
      int unsigned s;
      s = int'(a) + int'(b) + int'(cin);
      return (WIDTH+1)'(s);
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      logic prev_done;
      logic [WIDTH:0] e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.done) begin
            check("done_one_cycle", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1, want no pending result (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("result", 64'({bus.carry_out, bus.sum}), 64'(e));
            end
         end
         prev_done = rst_n && bus.done;
      end
   end

   // mode 0: plain; 1: re-pulse start mid-operation with junk a; 2: pulse start during DONE.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         input int mode);
      int n;
      int guard;
      guard = 0;
      while (bus.busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("idle_wait_timeout", 64'(bus.busy), 64'd0);
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      bus.start = 1'b1;
      exp_q.push_back(ref_add(a, b, cin));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      bus.cin   = 1'($urandom);
      if (mode != 0) check("busy_after_start", 64'(bus.busy), 64'd1);
      n = 1;
      while (!bus.done && n < 50) begin
         if (mode == 1 && n == 3) begin
            bus.start = 1'b1;
            bus.a     = 8'hAA;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      check("done_latency", 64'(n), 64'(WIDTH + 1));
      if (mode == 2) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("idle_after_done", 64'({bus.busy, bus.done}), 64'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic rc;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_result", 64'({bus.carry_out, bus.sum}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'h35, 8'h4A, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 0);
      run_op(8'hFF, 8'hFF, 1'b1, 0);
      run_op(8'h00, 8'h00, 1'b0, 0);
      run_op(8'h10, 8'h20, 1'b0, 1);
      run_op(8'h5A, 8'h33, 1'b1, 2);

      // Abort mid-operation: partial sum is nonzero, so clearing must be visible.
      bus.a     = 8'hFF;
      bus.b     = 8'h00;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_result", 64'({bus.carry_out, bus.sum}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(8'hC3, 8'h7E, 1'b1, 0);

      for (int i = 0; i < 1000; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom);
         run_op(ra, rb, rc, ($urandom_range(0, 3) == 0) ? 2 : 0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
